// File: rtl/serial_adder_seq_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master drives the request and operands. The slave returns status and the result.
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell is reused LSB first over WIDTH cycles.
// The carry is registered between bits, and a single done pulse accompanies each result.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sacc;
  logic [WIDTH-1:0] sacc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             c_nxt;
  logic             s_bit;
  logic             busy_q;
  logic             done_q;
  logic             cout_q;

  // One-bit full-adder cell. It returns the carry and the sum as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (y & ci) | (x & ci), x ^ y ^ ci};
  endfunction

  always_comb begin
    {c_nxt, s_bit} = full_add(sa[0], sb[0], c);
    sacc_nxt = sacc >> 1;
    sacc_nxt[WIDTH-1] = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sacc   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        // DONE accepts a new request directly, so results can follow back-to-back.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            c      <= bus.cin;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          c    <= c_nxt;
          sacc <= sacc_nxt;
          cnt  <= cnt + CNT_W'(1);
          // Results are committed only here, so sum and cout never show a partial value.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum_q  <= sacc_nxt;
            cout_q <= c_nxt;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule
